dyn_bank_allocator: RTL and testbench

Per-bank ownership controller for the dynamic shared-VC buffer. It grants exactly one input port the right to allocate this bank's shared VCs, and detects sustained per-port congestion with saturating counters. Before reassigning ownership, it drains the bank so that no shared VC is still held by the old owner. When congestion clears, it returns the bank to its home port. One instance per bank sits beside the VC allocator in the router.

---
 rtl/dyn_bank_allocator_pkg.sv | 39 +++
 rtl/dyn_bank_allocator_counter.sv | 31 +++
 rtl/dyn_bank_allocator.sv | 152 +++++++++++++++
 tb/tb_dyn_bank_allocator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dyn_bank_allocator_pkg.sv
// Shared definitions for the dynamic shared-VC bank allocator.
//   bank_state_e : ownership FSM encoding (ENABLE / DRAIN / SWITCH).
//   onehot()     : index -> one-hot vector (caller truncates to port count).
//   rr_first_set : first set request bit in round-robin order from a start index.
package dyn_bank_allocator_pkg;

  // Upper bound on router ports that the helpers handle; indices use 5 bits.
  localparam int MAX_PORTS = 32;

  typedef enum logic [1:0] {
    ST_ENABLE = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_SWITCH = 2'b11
  } bank_state_e;

  function automatic logic [MAX_PORTS-1:0] onehot(input int idx);
    logic [MAX_PORTS-1:0] vec;
    vec = '0;
    vec[idx[4:0]] = 1'b1;
    return vec;
  endfunction

  // Scans start, start+1, ... (mod n). Walking k downwards lets the lowest
  // offset overwrite the result, so the first hit in rotation order wins.
  // Returns start when nothing is set; callers qualify with |req.
  function automatic int rr_first_set(input logic [MAX_PORTS-1:0] req,
                                      input int start, input int n);
    int idx;
    int sel;
    sel = start;
    for (int k = MAX_PORTS - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= n) idx = idx - n;
      if (k < n && req[idx[4:0]]) sel = idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/dyn_bank_allocator_counter.sv
// bank_congestion_counter: saturating run-length counter for one input port.
//   clk, reset : clock, asynchronous active-low reset.
//   busy       : the port's private slice of this bank is fully allocated.
//   enable     : counting permitted (allocator FSM in ENABLE).
//   congested  : counter sits at its maximum value.
// Any cycle without busy && enable clears the count: no partial credit.
module bank_congestion_counter #(
  parameter int width = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic enable,
  output logic congested
);

  logic [width-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (busy && enable) begin
      if (count != '1) count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  assign congested = (count == '1);

endmodule

// File: rtl/dyn_bank_allocator.sv
// dyn_bank_allocator: ownership controller for one shared-VC bank.
// Grants one input port the right to allocate this bank's shared VCs, moves
// the grant to congested ports (round-robin), drains the bank before each
// move, and returns the bank to its home port once congestion has cleared.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset.
//   allocated_ip_ivc        : private VC busy flags, port-major.
//   allocated_ip_shared_ivc : shared VC busy flags, port-major.
//   shared_ivc_empty        : this bank's shared VC buffers are empty.
//   memory_bank_grant_out   : one-hot owner of this bank.
//   ready_for_allocation    : VC allocator may allocate this bank's shared VCs.
//   switch_pulse            : one-cycle strobe on the cycle the grant changes.
//   state_dbg               : current FSM state encoding.
// Handshake: ready_for_allocation is a level, high exactly while the FSM is in
// ENABLE. It drops on the edge that enters DRAIN; the VC allocator must start
// no new allocation in this bank while it is low, and may resume on the cycle
// it returns high, which is the same cycle the new grant becomes visible.
module dyn_bank_allocator
  import dyn_bank_allocator_pkg::*;
#(
  parameter int num_ports     = 5,
  parameter int num_vcs       = 10,
  parameter int num_banks     = 5,   // must divide num_vcs exactly
  parameter int bank_id       = 0,
  parameter int counter_width = 4,
  parameter int hold_cycles   = 8,
  parameter int release_width = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_ports*num_vcs-1:0] allocated_ip_ivc,
  input  logic [num_ports*num_vcs-1:0] allocated_ip_shared_ivc,
  input  logic [num_vcs/num_banks-1:0] shared_ivc_empty,
  output logic [num_ports-1:0]         memory_bank_grant_out,
  output logic                         ready_for_allocation,
  output logic                         switch_pulse,
  output logic [1:0]                   state_dbg
);

  localparam int vcs_per_bank = num_vcs / num_banks;
  localparam int home         = bank_id % num_ports;
  localparam int pw           = (num_ports > 1) ? $clog2(num_ports) : 1;
  localparam int hw           = (hold_cycles > 0) ? $clog2(hold_cycles + 1) : 1;
  localparam logic [pw-1:0] home_idx = pw'(home);
  localparam logic [pw-1:0] rr_init  = pw'((home + 1) % num_ports);
  localparam logic [pw-1:0] last_idx = pw'(num_ports - 1);

  bank_state_e state, next_state;

  logic [pw-1:0]            owner, next_owner, rr_ptr, target, rr_sel;
  logic [hw-1:0]            hold_cnt;
  logic [release_width-1:0] release_cnt;
  logic [num_ports-1:0]     busy, shared_busy, congested;
  logic                     drained, any_congested;
  logic                     unused_bits;

  // Only this bank's slices are consumed; the rest of the flag vectors
  // belong to other bank instances.
  assign unused_bits = ^{allocated_ip_ivc, allocated_ip_shared_ivc};

  for (genvar p = 0; p < num_ports; p++) begin : g_port
    localparam int base = p * num_vcs + bank_id * vcs_per_bank;
    assign busy[p]        = &allocated_ip_ivc[base +: vcs_per_bank];
    assign shared_busy[p] = |allocated_ip_shared_ivc[base +: vcs_per_bank];

    bank_congestion_counter #(.width(counter_width)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .busy      (busy[p]),
      .enable    (state == ST_ENABLE),
      .congested (congested[p])
    );
  end

  assign any_congested = |congested;
  // The grant register is one-hot of owner, so masking avoids a variable index.
  assign drained = (&shared_ivc_empty) && !(|(shared_busy & memory_bank_grant_out));

  always_comb begin
    rr_sel = pw'(rr_first_set(MAX_PORTS'(congested), int'(rr_ptr), num_ports));
    target = owner;
    if (any_congested) begin
      target = rr_sel;
    end else if (release_cnt == '1 && owner != home_idx) begin
      target = home_idx;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_ENABLE: if (target != owner && hold_cnt == '0) next_state = ST_DRAIN;
      ST_DRAIN:  if (drained) next_state = ST_SWITCH;
      ST_SWITCH: next_state = ST_ENABLE;
      default:   next_state = ST_ENABLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_ENABLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner                 <= home_idx;
      next_owner            <= home_idx;
      memory_bank_grant_out <= num_ports'(onehot(home));
      rr_ptr                <= rr_init;
      hold_cnt              <= '0;
      release_cnt           <= '0;
      switch_pulse          <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      case (state)
        ST_ENABLE, ST_DRAIN: begin
          if (state == ST_ENABLE) begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
            // next_owner is captured only on the ENABLE->DRAIN edge.
            if (next_state == ST_DRAIN) next_owner <= target;
          end
          if (!any_congested && owner != home_idx) begin
            if (release_cnt != '1) release_cnt <= release_cnt + 1'b1;
          end else begin
            release_cnt <= '0;
          end
        end
        ST_SWITCH: begin
          owner                 <= next_owner;
          memory_bank_grant_out <= num_ports'(onehot(int'(next_owner)));
          rr_ptr                <= (next_owner == last_idx) ? '0 : next_owner + 1'b1;
          hold_cnt              <= hw'(hold_cycles);
          release_cnt           <= '0;
          switch_pulse          <= 1'b1;
        end
        default: begin
          owner                 <= home_idx;
          next_owner            <= home_idx;
          memory_bank_grant_out <= num_ports'(onehot(home));
          rr_ptr                <= rr_init;
          hold_cnt              <= '0;
          release_cnt           <= '0;
          switch_pulse          <= 1'b0;
        end
      endcase
    end
  end

  assign ready_for_allocation = (state == ST_ENABLE);
  assign state_dbg            = state;

endmodule

// File: tb/tb_dyn_bank_allocator.sv
module tb_dyn_bank_allocator;

  localparam int NP   = 5;
  localparam int NV   = 10;
  localparam int VPB  = 2;
  localparam int BANK = 2;
  localparam int HOME = 2;
  localparam int CMAX = 3;
  localparam int HOLD = 4;
  localparam int RMAX = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NP*NV-1:0] priv;
  logic [NP*NV-1:0] shared;
  logic [VPB-1:0]   empty;
  logic [NP-1:0]    grant;
  logic             ready;
  logic             pulse;
  logic [1:0]       state_dbg;

  dyn_bank_allocator #(
    .num_ports(NP), .num_vcs(NV), .num_banks(5), .bank_id(BANK),
    .counter_width(2), .hold_cycles(HOLD), .release_width(3)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .allocated_ip_ivc        (priv),
    .allocated_ip_shared_ivc (shared),
    .shared_ivc_empty        (empty),
    .memory_bank_grant_out   (grant),
    .ready_for_allocation    (ready),
    .switch_pulse            (pulse),
    .state_dbg               (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // mode: 0 = granting, 1 = waiting for bank to empty, 2 = handing over
  int m_owner, m_mode, m_next, m_rr, m_hold, m_rel;
  int m_run[NP];
  bit m_pulse;

  function automatic bit port_busy(input int p);
    return &priv[p*NV + BANK*VPB +: VPB];
  endfunction

  task automatic model_reset();
    m_owner = HOME; m_mode = 0; m_next = HOME; m_rr = (HOME + 1) % NP;
    m_hold = 0; m_rel = 0; m_pulse = 0;
    for (int p = 0; p < NP; p++) m_run[p] = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int tgt;
    int old_mode;
    bit anyc;
    bit drained;
    old_mode = m_mode;
    anyc = 0;
    for (int p = 0; p < NP; p++) if (m_run[p] == CMAX) anyc = 1;
    tgt = m_owner;
    if (anyc) begin
      for (int k = NP - 1; k >= 0; k--)
        if (m_run[(m_rr + k) % NP] == CMAX) tgt = (m_rr + k) % NP;
    end else if (m_rel == RMAX && m_owner != HOME) begin
      tgt = HOME;
    end
    drained = (&empty) && (shared[m_owner*NV + BANK*VPB +: VPB] == '0);
    m_pulse = (old_mode == 2);
    if (old_mode == 2)                    m_rel = 0;
    else if (!anyc && m_owner != HOME)    m_rel = (m_rel < RMAX) ? m_rel + 1 : RMAX;
    else                                  m_rel = 0;
    for (int p = 0; p < NP; p++) begin
      if (old_mode == 0 && port_busy(p)) m_run[p] = (m_run[p] < CMAX) ? m_run[p] + 1 : CMAX;
      else                               m_run[p] = 0;
    end
    case (old_mode)
      0: begin
        if (tgt != m_owner && m_hold == 0) begin
          m_next = tgt;
          m_mode = 1;
        end
        if (m_hold > 0) m_hold = m_hold - 1;
      end
      1: if (drained) m_mode = 2;
      default: begin
        m_owner = m_next;
        m_rr    = (m_next + 1) % NP;
        m_hold  = HOLD;
        m_mode  = 0;
      end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input string tag);
    logic [7:0] exp_grant;
    exp_grant = 8'(1 << m_owner);
    check({tag, "_grant"}, 8'(grant), exp_grant);
    check({tag, "_ready"}, 8'(ready), 8'(m_mode == 0));
    check({tag, "_pulse"}, 8'(pulse), 8'(m_pulse));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    model_check(tag);
  endtask

  task automatic set_busy(input int p, input bit b);
    priv[p*NV + BANK*VPB +: VPB] = b ? 2'b11 : 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; priv = '0; shared = '0; empty = 2'b11;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 8'(grant), 8'h04);
    check("rst_ready", 8'(ready), 8'h01);
    check("rst_pulse", 8'(pulse), 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Port 0 congested, bank already empty: minimum-latency switch.
    set_busy(0, 1);
    repeat (3) step("s2_count");
    set_busy(0, 0);
    step("s2_drain");
    check("s2_ready_low", 8'(ready), 8'h00);
    step("s2_switch");
    check("s2_old_grant", 8'(grant), 8'h04);
    step("s2_new");
    check("s2_grant_p0", 8'(grant), 8'h01);
    check("s2_pulse_hi", 8'(pulse), 8'h01);

    // Idle: release counter returns the bank home after 7 cycles.
    repeat (7) step("s5_idle");
    check("s5_still_p0", 8'(grant), 8'h01);
    check("s5_ready_hi", 8'(ready), 8'h01);
    step("s5_drain");
    check("s5_drain_ready", 8'(ready), 8'h00);
    step("s5_switch");
    step("s5_home");
    check("s5_grant_home", 8'(grant), 8'h04);
    check("s5_pulse", 8'(pulse), 8'h01);

    // Owner's shared slice stays busy: drain waits for it.
    repeat (4) step("s3_hold");
    shared[HOME*NV + BANK*VPB] = 1'b1;
    set_busy(0, 1);
    repeat (3) step("s3_count");
    set_busy(0, 0);
    step("s3_drain");
    for (int i = 0; i < 5; i++) begin
      step("s3_wait");
      check("s3_ready_low", 8'(ready), 8'h00);
      check("s3_grant_kept", 8'(grant), 8'h04);
    end
    shared = '0;
    step("s3_switch");
    check("s3_switch_grant", 8'(grant), 8'h04);
    step("s3_new");
    check("s3_grant_p0", 8'(grant), 8'h01);

    // Ports 1 and 3 congested together with rr_ptr=3.
    do_reset();
    set_busy(1, 1);
    set_busy(3, 1);
    repeat (3) step("s4_count");
    step("s4_drain");
    step("s4_switch");
    step("s4_first");
    check("s4_grant_p3", 8'(grant), 8'h08);
    repeat (3) step("s4_hold");
    step("s4_hold_end");
    check("s4_hold_blocks", 8'(ready), 8'h01);
    step("s4_drain2");
    check("s4_drain2_ready", 8'(ready), 8'h00);
    step("s4_switch2");
    step("s4_second");
    check("s4_grant_p1", 8'(grant), 8'h02);
    set_busy(1, 0);
    set_busy(3, 0);

    // Asynchronous reset while draining.
    do_reset();
    empty = 2'b00;
    set_busy(0, 1);
    repeat (3) step("s6_count");
    set_busy(0, 0);
    repeat (2) step("s6_drain");
    check("s6_in_drain", 8'(ready), 8'h00);
    #2;
    reset = 1'b0;
    #1;
    check("s6_async_grant", 8'(grant), 8'h04);
    check("s6_async_ready", 8'(ready), 8'h01);
    check("s6_async_pulse", 8'(pulse), 8'h00);
    model_reset();
    empty = 2'b11;
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the model.
    begin
      int sel[NP];
      for (int p = 0; p < NP; p++) sel[p] = 0;
      for (int n = 0; n < 600; n++) begin
        priv   = (NP*NV)'({$urandom(), $urandom()});
        shared = (NP*NV)'({$urandom(), $urandom()});
        for (int p = 0; p < NP; p++) begin
          if ($urandom_range(0, 3) == 0) sel[p] = $urandom_range(0, 2);
          case (sel[p])
            0:       priv[p*NV + BANK*VPB +: VPB] = 2'b00;
            1:       priv[p*NV + BANK*VPB +: VPB] = 2'b11;
            default: priv[p*NV + BANK*VPB +: VPB] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
          endcase
          if ($urandom_range(0, 2) != 0) shared[p*NV + BANK*VPB +: VPB] = 2'b00;
        end
        for (int b = 0; b < VPB; b++) empty[b] = ($urandom_range(0, 7) != 0);
        step("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
